// File: rtl/pc_ras_r32i.sv
// RV32I program counter with branch resolution, fetch stall, misaligned-target
// trap and a circular return-address stack predicting ret targets.
module pc_ras_r32i #(
  parameter int unsigned     dataW      = 32,
  parameter logic [dataW-1:0] RESET_ADDR = '0,
  parameter logic [dataW-1:0] TRAP_ADDR  = 'h100,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         Stall,
  input  logic                         TestBranch,
  input  logic                         AlwaysBranch,
  input  logic                         AbsoluteBranch,
  input  logic [2:0]                   PCBranchType,
  input  logic [dataW-1:0]             BranchAddr,
  input  logic                         EQ,
  input  logic                         NE,
  input  logic                         LT,
  input  logic                         LTU,
  input  logic                         GE,
  input  logic                         GEU,
  input  logic                         PushRA,
  input  logic                         PopRA,
  output logic [dataW-1:0]             ProgAddr,
  output logic [dataW-1:0]             LinkAddr,
  output logic                         Taken,
  output logic                         MisalignTrap,
  output logic [dataW-1:0]             RASTop,
  output logic                         RASValid,
  output logic [$clog2(RAS_DEPTH):0]   RASCount
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_e;

  logic [dataW-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    wp_m1;
  logic [CW-1:0]    count;
  logic             flag;
  logic             take;
  logic             trap;
  logic [dataW-1:0] target;
  logic             ras_en;
  logic             ras_we;
  logic [PW-1:0]    ras_waddr;

  always_comb begin
    flag = 1'b0;
    case (PCBranchType)
      BR_BEQ:  flag = EQ;
      BR_BNE:  flag = NE;
      BR_BLT:  flag = LT;
      BR_BGE:  flag = GE;
      BR_BLTU: flag = LTU;
      BR_BGEU: flag = GEU;
      default: flag = 1'b0;
    endcase
  end

  assign take     = AlwaysBranch | (TestBranch & flag);
  assign target   = AbsoluteBranch ? {BranchAddr[dataW-1:1], 1'b0}
                                   : ProgAddr + BranchAddr;
  assign trap     = take & (target[1:0] != 2'b00);
  assign LinkAddr = ProgAddr + dataW'(4);

  assign wp_m1    = wp - PW'(1);
  assign RASCount = count;
  assign RASValid = (count != '0);
  assign RASTop   = RASValid ? mem[wp_m1] : '0;

  // Push+pop on a non-empty stack replaces the top in place; on an empty
  // stack it degenerates to a plain push.
  assign ras_en    = reset & ~Stall & ~trap;
  assign ras_we    = ras_en & PushRA;
  assign ras_waddr = (PopRA && count != '0) ? wp_m1 : wp;

  always_ff @(posedge clock) begin
    if (ras_we) mem[ras_waddr] <= LinkAddr;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ProgAddr     <= RESET_ADDR;
      Taken        <= 1'b0;
      MisalignTrap <= 1'b0;
      wp           <= '0;
      count        <= '0;
    end else begin
      Taken        <= 1'b0;
      MisalignTrap <= 1'b0;
      if (!Stall) begin
        if (trap) begin
          ProgAddr     <= TRAP_ADDR;
          MisalignTrap <= 1'b1;
        end else begin
          ProgAddr <= take ? target : LinkAddr;
          Taken    <= take;
          if (PushRA && (!PopRA || count == '0)) begin
            wp <= wp + PW'(1);
            if (count != FULL) count <= count + CW'(1);
          end else if (PopRA && !PushRA && count != '0) begin
            wp    <= wp_m1;
            count <= count - CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_ras_r32i.sv
// Directed self-checking bench for pc_ras_r32i: sequencing, branches, trap,
// RAS push/pop/wrap, stall and reset-while-stalled.
module tb_pc_ras_r32i;

  logic        clock = 1'b0;
  logic        reset;
  logic        Stall, TestBranch, AlwaysBranch, AbsoluteBranch;
  logic [2:0]  PCBranchType;
  logic [31:0] BranchAddr;
  logic        EQ, NE, LT, LTU, GE, GEU;
  logic        PushRA, PopRA;
  logic [31:0] ProgAddr, LinkAddr, RASTop;
  logic        Taken, MisalignTrap, RASValid;
  logic [2:0]  RASCount;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fails  = 0;

  pc_ras_r32i #(
    .dataW(32),
    .RESET_ADDR(32'h0),
    .TRAP_ADDR(32'h100),
    .RAS_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .Stall(Stall),
    .TestBranch(TestBranch), .AlwaysBranch(AlwaysBranch),
    .AbsoluteBranch(AbsoluteBranch), .PCBranchType(PCBranchType),
    .BranchAddr(BranchAddr),
    .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
    .PushRA(PushRA), .PopRA(PopRA),
    .ProgAddr(ProgAddr), .LinkAddr(LinkAddr), .Taken(Taken),
    .MisalignTrap(MisalignTrap), .RASTop(RASTop), .RASValid(RASValid),
    .RASCount(RASCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    Stall = 0; TestBranch = 0; AlwaysBranch = 0; AbsoluteBranch = 0;
    PCBranchType = 3'b000; BranchAddr = '0;
    EQ = 0; NE = 0; LT = 0; LTU = 0; GE = 0; GEU = 0;
    PushRA = 0; PopRA = 0;
  endtask

  task automatic jump(input logic abs, input logic [31:0] addr);
    idle();
    AlwaysBranch = 1; AbsoluteBranch = abs; BranchAddr = addr;
  endtask

  initial begin
    idle();
    reset = 0;
    tick(); tick();
    chk("rst_pc", ProgAddr, 32'h0);
    chk("rst_taken", {31'b0, Taken}, 32'h0);
    chk("rst_trap", {31'b0, MisalignTrap}, 32'h0);
    chk("rst_cnt", {29'b0, RASCount}, 32'h0);
    chk("rst_valid", {31'b0, RASValid}, 32'h0);
    chk("rst_top", RASTop, 32'h0);
    chk("rst_link", LinkAddr, 32'h4);

    reset = 1;
    tick(); chk("seq_4", ProgAddr, 32'h4);
    tick(); chk("seq_8", ProgAddr, 32'h8);
    chk("seq_taken", {31'b0, Taken}, 32'h0);

    jump(0, 32'd64); tick();
    chk("rel_72", ProgAddr, 32'd72);
    chk("rel_taken", {31'b0, Taken}, 32'h1);
    jump(1, 32'd65); tick();
    chk("abs_64", ProgAddr, 32'd64);
    chk("abs_taken", {31'b0, Taken}, 32'h1);
    idle(); tick();
    chk("after_jump", ProgAddr, 32'd68);
    chk("taken_pulse", {31'b0, Taken}, 32'h0);
    jump(1, 32'h4); tick();
    chk("abs_4", ProgAddr, 32'h4);
    jump(0, 32'hFFFF_FFF8); tick();
    chk("neg_wrap", ProgAddr, 32'hFFFF_FFFC);
    idle(); tick();
    chk("inc_wrap", ProgAddr, 32'h0);
    chk("inc_wrap_taken", {31'b0, Taken}, 32'h0);

    idle(); TestBranch = 1; PCBranchType = 3'b000; BranchAddr = 32'd16; tick();
    chk("beq_nt", ProgAddr, 32'h4);
    chk("beq_nt_taken", {31'b0, Taken}, 32'h0);
    EQ = 1; tick();
    chk("beq_t", ProgAddr, 32'd20);
    chk("beq_t_taken", {31'b0, Taken}, 32'h1);
    EQ = 1; NE = 1; LT = 1; LTU = 1; GE = 1; GEU = 1; PCBranchType = 3'b010; tick();
    chk("code010", ProgAddr, 32'd24);
    chk("code010_taken", {31'b0, Taken}, 32'h0);
    idle(); TestBranch = 1; PCBranchType = 3'b111; GEU = 1; BranchAddr = 32'd16; tick();
    chk("bgeu_t", ProgAddr, 32'd40);
    chk("bgeu_taken", {31'b0, Taken}, 32'h1);
    idle(); TestBranch = 1; PCBranchType = 3'b001; EQ = 1; BranchAddr = 32'd16; tick();
    chk("bne_nt", ProgAddr, 32'd44);
    idle(); TestBranch = 1; PCBranchType = 3'b100; LT = 1; BranchAddr = 32'd16; tick();
    chk("blt_t", ProgAddr, 32'd60);

    jump(0, 32'd6); PushRA = 1; tick();
    chk("trap_pc", ProgAddr, 32'h100);
    chk("trap_flag", {31'b0, MisalignTrap}, 32'h1);
    chk("trap_taken", {31'b0, Taken}, 32'h0);
    chk("trap_nopush", {29'b0, RASCount}, 32'h0);
    idle(); tick();
    chk("trap_next", ProgAddr, 32'h104);
    chk("trap_pulse", {31'b0, MisalignTrap}, 32'h0);
    jump(1, 32'h10); tick();
    chk("goto_10", ProgAddr, 32'h10);

    jump(0, 32'h10); PushRA = 1; tick();
    chk("push1_cnt", {29'b0, RASCount}, 32'h1);
    chk("push1_top", RASTop, 32'h14);
    chk("push1_pc", ProgAddr, 32'h20);
    tick(); tick(); tick(); tick();
    chk("push5_pc", ProgAddr, 32'h60);
    chk("push5_cnt", {29'b0, RASCount}, 32'h4);
    chk("push5_top", RASTop, 32'h54);
    chk("push5_valid", {31'b0, RASValid}, 32'h1);

    idle(); PopRA = 1; tick();
    chk("pop1_top", RASTop, 32'h44);
    chk("pop1_cnt", {29'b0, RASCount}, 32'h3);
    tick(); chk("pop2_top", RASTop, 32'h34);
    tick(); chk("pop3_top", RASTop, 32'h24);
    chk("pop3_cnt", {29'b0, RASCount}, 32'h1);
    tick();
    chk("pop4_top", RASTop, 32'h0);
    chk("pop4_valid", {31'b0, RASValid}, 32'h0);
    chk("pop4_cnt", {29'b0, RASCount}, 32'h0);
    tick();
    chk("underflow_cnt", {29'b0, RASCount}, 32'h0);
    chk("underflow_pc", ProgAddr, 32'h74);

    PushRA = 1; PopRA = 1; tick();
    chk("pp_empty_cnt", {29'b0, RASCount}, 32'h1);
    chk("pp_empty_top", RASTop, 32'h78);
    tick();
    chk("pp_repl_cnt", {29'b0, RASCount}, 32'h1);
    chk("pp_repl_top", RASTop, 32'h7C);
    chk("pp_repl_pc", ProgAddr, 32'h7C);

    jump(0, 32'h40); PushRA = 1; Stall = 1; tick();
    chk("stall_pc", ProgAddr, 32'h7C);
    chk("stall_taken", {31'b0, Taken}, 32'h0);
    chk("stall_cnt", {29'b0, RASCount}, 32'h1);
    reset = 0; tick();
    chk("rst_stall_pc", ProgAddr, 32'h0);
    chk("rst_stall_cnt", {29'b0, RASCount}, 32'h0);
    chk("rst_stall_top", RASTop, 32'h0);
    chk("rst_stall_taken", {31'b0, Taken}, 32'h0);
    reset = 1; idle(); tick();
    chk("post_rst_pc", ProgAddr, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_ras_r32i.md
# pc_ras_r32i

Parametrised successor to the RV32I program counter. Holds the fetch address and resolves conditional and unconditional branches from the comparator flags and the `branchcodes.sv` encodings. Adds fetch stall, misaligned-target trapping and a circular return-address stack (RAS) that predicts `ret` targets for the fetch stage. Sits between the decode/branch-compare logic and instruction memory.

## Interface
Parameters:
- dataW, 32, address/data width
- RESET_ADDR, 0, ProgAddr value after reset
- TRAP_ADDR, 32'h100, redirect target on a misaligned branch target
- RAS_DEPTH, 4, RAS entries; power of two, ≥2

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clock
- Stall  in  1  hold all state this cycle
- TestBranch  in  1  evaluate conditional branch per PCBranchType
- AlwaysBranch  in  1  unconditional jump (JAL/JALR)
- AbsoluteBranch  in  1  target = BranchAddr with bit 0 cleared (JALR); else PC-relative
- PCBranchType  in  3  `BEQ`/`BNE`/`BLT`/`BGE`/`BLTU`/`BGEU` (funct3: 000/001/100/101/110/111)
- BranchAddr  in  dataW  signed offset or absolute target
- EQ, NE, LT, LTU, GE, GEU  in  1 each  comparator flags
- PushRA  in  1  push link address onto RAS
- PopRA  in  1  pop RAS
- ProgAddr  out  dataW  current fetch address (registered)
- LinkAddr  out  dataW  ProgAddr+4, combinational
- Taken  out  1  registered pulse: last update was a taken branch/jump
- MisalignTrap  out  1  registered pulse: last update trapped
- RASTop  out  dataW  predicted return address; 0 when empty
- RASValid  out  1  RAS count ≠ 0
- RASCount  out  $clog2(RAS_DEPTH)+1  entries held

## Operation
- cond = TestBranch & flag selected by PCBranchType; codes 010/011 → cond = 0.
- take = AlwaysBranch | cond.
- target = AbsoluteBranch ? {BranchAddr[dataW-1:1],1'b0} : ProgAddr + BranchAddr, modulo 2^dataW (wrap, no overflow flag).
- Per edge, reset high, Stall low, priority order:
  - take & target[1:0]≠0 → ProgAddr←TRAP_ADDR, MisalignTrap←1, Taken←0, RAS unchanged (Push/Pop ignored).
  - take → ProgAddr←target, Taken←1, MisalignTrap←0.
  - else → ProgAddr←ProgAddr+4 (wraps at 2^dataW), Taken←0, MisalignTrap←0.
- Stall high: ProgAddr, RAS held; Taken, MisalignTrap←0; Push/Pop ignored.
- RAS (applied only when not stalled and not trapping): circular buffer, write pointer wp, count.
  - Push only: mem[wp]←LinkAddr, wp←wp+1 (mod depth), count←min(count+1, RAS_DEPTH). Full push overwrites oldest.
  - Pop only: count>0 → wp←wp−1, count←count−1; count=0 → no change (underflow ignored).
  - Push & Pop: mem[wp−1]←LinkAddr, wp/count unchanged; if count=0, behaves as push (count←1).
  - RASTop = count≠0 ? mem[wp−1] : 0.
- Reset (reset low at edge): ProgAddr=RESET_ADDR, Taken=0, MisalignTrap=0, wp=0, RASCount=0, RASValid=0, RASTop=0; overrides Stall and all requests. RAS storage need not be cleared.

## Timing
- Branch decision to ProgAddr: 1 cycle; inputs sampled on the same edge that updates ProgAddr.
- LinkAddr follows ProgAddr combinationally, same cycle.
- Taken/MisalignTrap high exactly one cycle per event, aligned with the new ProgAddr.
- RASTop/RASValid/RASCount update on the edge after the push/pop.
- Reset mid-branch or mid-stall: next edge yields reset state; first increment on the first edge with reset high.

## Test plan
- Reset low 2 cycles, release, no requests → ProgAddr 0, 4, 8, 12 on successive edges; Taken=0, RASValid=0.
- At ProgAddr=8: AlwaysBranch, BranchAddr=64 relative → 72, Taken pulse; AbsoluteBranch, BranchAddr=65 → 64; BranchAddr=−8 at 4 → 0xFFFF_FFFC wrap correct.
- TestBranch, `BEQ`, EQ=0 → +4; EQ=1, offset 16 → PC+16, Taken 1 cycle; PCBranchType=010 with all flags 1 → +4; `BGEU` with GEU=1 → taken.
- Relative offset 6 with AlwaysBranch → ProgAddr=0x100, MisalignTrap 1 cycle, PushRA same cycle ignored (RASCount unchanged).
- RAS_DEPTH=4: push at PC 0x10,0x20,0x30,0x40,0x50 → RASCount 4, RASTop 0x54; pops yield 0x44,0x34,0x24 then empty (RASTop 0, RASValid 0); extra pop keeps count 0; push+pop on empty → count 1.
- Stall during AlwaysBranch → ProgAddr held, Taken 0; reset low while stalled mid-branch → ProgAddr=RESET_ADDR, RASCount 0 next edge.
